// File: rtl/vga_pkg.sv
// Shared VGA timing constants (640x480 @ 60 Hz from a 100 MHz system clock).
// Used by the timing generator and by the game-logic/output block for its
// screen bounds.
//   VGA_CNT_W          : width of the column/line counters
//   VGA_CLK_DIV        : clk cycles per pixel
//   VGA_H_* / VGA_V_*  : horizontal/vertical totals, sync widths, visible span
//   vga_in_span()      : half-open range test on a counter value
package vga_pkg;

  localparam int VGA_CNT_W       = 10;
  localparam int VGA_CLK_DIV     = 4;
  localparam int VGA_H_TOTAL     = 800;
  localparam int VGA_H_SYNC      = 96;
  localparam int VGA_H_VIS_START = 144;
  localparam int VGA_H_VIS_END   = 784;
  localparam int VGA_V_TOTAL     = 525;
  localparam int VGA_V_SYNC      = 2;
  localparam int VGA_V_VIS_START = 35;
  localparam int VGA_V_VIS_END   = 515;

  // True when lo <= x < hi.
  function automatic logic vga_in_span(input logic [VGA_CNT_W-1:0] x,
                                       input int lo, input int hi);
    return (x >= VGA_CNT_W'(lo)) && (x < VGA_CNT_W'(hi));
  endfunction

endpackage

// File: rtl/pix_clk_en.sv
// Pixel clock-enable divider.
// A counter runs 0..CLK_DIV-1 and wraps; pix_tick is high exactly in the
// cycle the counter holds CLK_DIV-1, so after reset release the first strobe
// falls in the CLK_DIV-th clk cycle.
//   clk      : system clock
//   clr_n    : asynchronous active-low reset (counter to 0, strobe low)
//   pix_tick : one-clk pixel-enable strobe
module pix_clk_en #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic clr_n,
  output logic pix_tick
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  // Decoded from the register so the strobe is glitch-free and low in reset
  // (for CLK_DIV > 1).
  assign pix_tick = (div_cnt == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: pixel strobe, column/line counters, sync and
// visible-region decode, and an end-of-frame strobe for the game update.
//   clk        : system clock
//   clr_n      : asynchronous active-low reset
//   h_Counter  : current column, 0..H_TOTAL-1
//   v_Counter  : current line, 0..V_TOTAL-1
//   display_On : current pixel lies in the visible region
//   hsync      : horizontal sync, active low (h_Counter < H_SYNC)
//   vsync      : vertical sync, active low (v_Counter < V_SYNC)
//   pix_Tick   : one-clk pixel-enable strobe
//   frame_Tick : one-clk strobe on the last pixel tick of the frame
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV     = VGA_CLK_DIV,
  parameter int H_TOTAL     = VGA_H_TOTAL,
  parameter int H_SYNC      = VGA_H_SYNC,
  parameter int H_VIS_START = VGA_H_VIS_START,
  parameter int H_VIS_END   = VGA_H_VIS_END,
  parameter int V_TOTAL     = VGA_V_TOTAL,
  parameter int V_SYNC      = VGA_V_SYNC,
  parameter int V_VIS_START = VGA_V_VIS_START,
  parameter int V_VIS_END   = VGA_V_VIS_END
) (
  input  logic                 clk,
  input  logic                 clr_n,
  output logic [VGA_CNT_W-1:0] h_Counter,
  output logic [VGA_CNT_W-1:0] v_Counter,
  output logic                 display_On,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 pix_Tick,
  output logic                 frame_Tick
);

  localparam logic [VGA_CNT_W-1:0] H_LAST = VGA_CNT_W'(H_TOTAL - 1);
  localparam logic [VGA_CNT_W-1:0] V_LAST = VGA_CNT_W'(V_TOTAL - 1);

  logic                 pix_tick;
  logic [VGA_CNT_W-1:0] h_cnt;
  logic [VGA_CNT_W-1:0] v_cnt;
  logic                 h_last;
  logic                 v_last;

  pix_clk_en #(
    .CLK_DIV (CLK_DIV)
  ) u_pix_clk_en (
    .clk      (clk),
    .clr_n    (clr_n),
    .pix_tick (pix_tick)
  );

  assign h_last = (h_cnt == H_LAST);
  assign v_last = (v_cnt == V_LAST);

  // Explicit wrap compares keep both counters inside 0..TOTAL-1 at all times.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_tick) begin
      if (h_last) begin
        h_cnt <= '0;
        v_cnt <= v_last ? '0 : v_cnt + VGA_CNT_W'(1);
      end else begin
        h_cnt <= h_cnt + VGA_CNT_W'(1);
      end
    end
  end

  assign h_Counter = h_cnt;
  assign v_Counter = v_cnt;

  // Decodes come straight off the counter registers: no skew to the counts,
  // and in reset they resolve to the counter-0 values (syncs low, blank).
  assign hsync      = (h_cnt >= VGA_CNT_W'(H_SYNC));
  assign vsync      = (v_cnt >= VGA_CNT_W'(V_SYNC));
  assign display_On = vga_in_span(h_cnt, H_VIS_START, H_VIS_END) &&
                      vga_in_span(v_cnt, V_VIS_START, V_VIS_END);
  assign pix_Tick   = pix_tick;
  assign frame_Tick = pix_tick && h_last && v_last;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a scaled-down instance for whole-frame and reset
// behaviour, plus a default-parameter instance for release timing.
module tb_vga_timing_gen;

  // Scaled timing so several frames fit in a short run.
  localparam int SD   = 2;
  localparam int SH   = 20;
  localparam int SHS  = 3;
  localparam int SHVS = 5;
  localparam int SHVE = 17;
  localparam int SV   = 10;
  localparam int SVS  = 2;
  localparam int SVVS = 3;
  localparam int SVVE = 8;

  logic       clk;
  logic       clr_n;

  logic [9:0] s_h, s_v;
  logic       s_disp, s_hs, s_vs, s_pt, s_ft;
  logic [9:0] d_h, d_v;
  logic       d_disp, d_hs, d_vs, d_pt, d_ft;

  logic [24:0] s_vec, d_vec;
  assign s_vec = {s_h, s_v, s_disp, s_hs, s_vs, s_pt, s_ft};
  assign d_vec = {d_h, d_v, d_disp, d_hs, d_vs, d_pt, d_ft};

  int checks;
  int failures;

  vga_timing_gen #(
    .CLK_DIV(SD), .H_TOTAL(SH), .H_SYNC(SHS), .H_VIS_START(SHVS),
    .H_VIS_END(SHVE), .V_TOTAL(SV), .V_SYNC(SVS), .V_VIS_START(SVVS),
    .V_VIS_END(SVVE)
  ) u_small (
    .clk(clk), .clr_n(clr_n), .h_Counter(s_h), .v_Counter(s_v),
    .display_On(s_disp), .hsync(s_hs), .vsync(s_vs),
    .pix_Tick(s_pt), .frame_Tick(s_ft)
  );

  vga_timing_gen u_dflt (
    .clk(clk), .clr_n(clr_n), .h_Counter(d_h), .v_Counter(d_v),
    .display_On(d_disp), .hsync(d_hs), .vsync(d_vs),
    .pix_Tick(d_pt), .frame_Tick(d_ft)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: n = clk edges since reset release. Completed pixel ticks are
  // n / SD; the pixel's column/line follow from plain division.
  function automatic logic [24:0] exp_small(input int n);
    int p, h, v;
    logic tick, ft, hs, vs, disp;
    p    = n / SD;
    h    = p % SH;
    v    = (p / SH) % SV;
    tick = (n % SD) == SD - 1;
    ft   = tick && (h == SH - 1) && (v == SV - 1);
    hs   = h >= SHS;
    vs   = v >= SVS;
    disp = (h >= SHVS) && (h < SHVE) && (v >= SVVS) && (v < SVVE);
    return {10'(h), 10'(v), disp, hs, vs, tick, ft};
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    clr_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (s_vec !== 25'd0) begin
        failures++;
        $display("FAIL reset_small i=%0d got=%h exp=%h", i, s_vec, 25'd0);
      end
      checks++;
      if (d_vec !== 25'd0) begin
        failures++;
        $display("FAIL reset_dflt i=%0d got=%h exp=%h", i, d_vec, 25'd0);
      end
    end
  endtask

  task automatic test_release_default();
    logic [24:0] exp;
    int h;
    clr_n = 1'b1;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      h   = k / 4;
      exp = {10'(h), 10'd0, 1'b0, (h >= 96), 1'b0, (k % 4 == 3), 1'b0};
      checks++;
      if (d_vec !== exp) begin
        failures++;
        $display("FAIL release_dflt k=%0d got=%h exp=%h", k, d_vec, exp);
      end
      if (k == 20) begin
        checks++;
        if (d_h !== 10'd5 || d_v !== 10'd0) begin
          failures++;
          $display("FAIL fifth_tick h=%0d v=%0d exp h=5 v=0", d_h, d_v);
        end
      end
    end
  endtask

  task automatic test_full_frames();
    logic [24:0] exp;
    int act, vlow, hlow, ftc, ft_first, ft_gap;
    act = 0; vlow = 0; hlow = 0; ftc = 0; ft_first = -1; ft_gap = 0;
    clr_n = 1'b0;
    repeat (2) @(negedge clk);
    clr_n = 1'b1;
    for (int n = 1; n <= 2 * SH * SV * SD; n++) begin
      @(negedge clk);
      exp = exp_small(n);
      checks++;
      if (s_vec !== exp) begin
        failures++;
        $display("FAIL frame_run n=%0d got=%h exp=%h", n, s_vec, exp);
      end
      if (s_pt === 1'b1) begin
        if (s_disp === 1'b1) act++;
        if (s_vs === 1'b0) vlow++;
        if (s_hs === 1'b0) hlow++;
      end
      if (s_ft === 1'b1) begin
        ftc++;
        if (ft_first < 0) ft_first = n;
        else ft_gap = n - ft_first;
      end
    end
    checks++;
    if (act != 2 * (SHVE - SHVS) * (SVVE - SVVS)) begin
      failures++;
      $display("FAIL active_pixels got=%0d exp=%0d", act,
               2 * (SHVE - SHVS) * (SVVE - SVVS));
    end
    checks++;
    if (vlow != 2 * SVS * SH) begin
      failures++;
      $display("FAIL vsync_low got=%0d exp=%0d", vlow, 2 * SVS * SH);
    end
    checks++;
    if (hlow != 2 * SHS * SV) begin
      failures++;
      $display("FAIL hsync_low got=%0d exp=%0d", hlow, 2 * SHS * SV);
    end
    checks++;
    if (ftc != 2 || ft_gap != SH * SV * SD) begin
      failures++;
      $display("FAIL frame_tick count=%0d gap=%0d exp count=2 gap=%0d",
               ftc, ft_gap, SH * SV * SD);
    end
  endtask

  task automatic test_mid_reset();
    logic [24:0] exp;
    int len, hold;
    clr_n = 1'b0;
    @(negedge clk);
    for (int it = 0; it < 5; it++) begin
      clr_n = 1'b1;
      // First pass lands on column 10, line 5 (mid-line, mid-frame).
      len = (it == 0) ? (5 * SH + 10) * SD : $urandom_range(30, 900);
      for (int n = 1; n <= len; n++) begin
        @(negedge clk);
        exp = exp_small(n);
        checks++;
        if (s_vec !== exp) begin
          failures++;
          $display("FAIL mid_run it=%0d n=%0d got=%h exp=%h", it, n, s_vec, exp);
        end
      end
      // Assert between clock edges: outputs must clear without a clk edge.
      #2 clr_n = 1'b0;
      #1;
      checks++;
      if (s_vec !== 25'd0 || d_vec !== 25'd0) begin
        failures++;
        $display("FAIL async_reset it=%0d small=%h dflt=%h exp=0", it, s_vec, d_vec);
      end
      hold = $urandom_range(1, 3);
      for (int j = 0; j < hold; j++) begin
        @(negedge clk);
        checks++;
        if (s_vec !== 25'd0) begin
          failures++;
          $display("FAIL reset_hold it=%0d got=%h exp=%h", it, s_vec, 25'd0);
        end
      end
    end
    clr_n = 1'b1;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      exp = exp_small(n);
      checks++;
      if (s_vec !== exp) begin
        failures++;
        $display("FAIL restart n=%0d got=%h exp=%h", n, s_vec, exp);
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    checks   = 0;
    failures = 0;
    clr_n    = 1'b0;
    test_reset();
    test_release_default();
    test_full_frames();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
